// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers. The result is computed
// from the latched operands and written to HI/LO only when the latency counter expires.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] input_1,
  input  logic [31:0] input_2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_op_e        op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic          accept_md;
  logic          done;
  logic [63:0]   prod_u, prod_s;
  logic          div_signed;
  logic [31:0]   a_mag, b_mag, b_safe, quo_u, rem_u, quo, rem;

  assign accept_md = (state_q == IDLE) && start && !md_op[2];
  assign done      = (state_q == RUN) && (cnt_q == CW'(1));

  // Datapath works on the latched operands; ports are free to change after acceptance.
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

  // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign div_signed = (op_q == OP_DIV);
  assign a_mag      = (div_signed && a_q[31]) ? -a_q : a_q;
  assign b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
  assign b_safe     = (b_q == 32'd0) ? 32'd1 : b_mag;
  assign quo_u      = a_mag / b_safe;
  assign rem_u      = a_mag % b_safe;
  assign quo        = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_u : quo_u;
  assign rem        = (div_signed && a_q[31]) ? -rem_u : rem_u;

  // NOTE: every register, including the operand latches, is reset here so a reset
  // mid-operation leaves no stale state; sequential state always uses non-blocking <=.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_md) state_d = RUN;
      RUN:     if (done)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: each variable gets a hold default first, so no path through this block infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (state_q == IDLE && start) begin
      unique case (md_op_e'(md_op))
        OP_MULT, OP_MULTU: begin
          cnt_d = CW'(MULT_CYCLES);
          op_d  = md_op_e'(md_op);
          a_d   = input_1;
          b_d   = input_2;
        end
        OP_DIV, OP_DIVU: begin
          cnt_d = CW'(DIV_CYCLES);
          op_d  = md_op_e'(md_op);
          a_d   = input_1;
          b_d   = input_2;
        end
        OP_MTHI: hi_d = input_1;
        OP_MTLO: lo_d = input_1;
        default: ;
      endcase
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (done) begin
        unique case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
          OP_DIV, OP_DIVU: begin
            if (b_q != 32'd0) begin
              hi_d = rem;
              lo_d = quo;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios followed by random operations,
// all compared against an arithmetic reference model of HI/LO.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] input_1, input_2;
  logic        busy;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .input_1 (input_1),
    .input_2 (input_2),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 5;
      3'd2, 3'd3: return 10;
      default:    return 0;
    endcase
  endfunction

  // Reference model: plain 64-bit arithmetic, SV division truncates toward zero.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp, sq, sr;
    logic [63:0] up;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = sp;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = up;
      end
      3'd2: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      3'd3: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge with busy low; returns at the negedge where busy is low again.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int          n;
    logic [31:0] h0, l0;
    h0 = m_hi;
    l0 = m_lo;
    start = 1'b1; md_op = op; input_1 = a; input_2 = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'($urandom); input_1 = $urandom; input_2 = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      if (n == 1) begin
        check({tag, ".hold_hi"}, hi, h0);
        check({tag, ".hold_lo"}, lo, l0);
      end
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, 32'(n), 32'(exp_cycles(op)));
    model_apply(op, a, b);
    check({tag, ".hi"}, hi, m_hi);
    check({tag, ".lo"}, lo, m_lo);
  endtask

  initial begin
    int          n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; md_op = '0; input_1 = '0; input_2 = '0;

    // Reset sequence
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.hi", hi, 32'h0);
    check("reset.lo", lo, 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    reset = 1'b1;
    run_op("mthi0", 3'd4, 32'h12345678, 32'h0);
    check("mthi0.hi_const", hi, 32'h12345678);
    check("mthi0.lo_const", lo, 32'h0);

    // Multiply
    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'h3);
    check("mult.hi_const", hi, 32'hFFFFFFFF);
    check("mult.lo_const", lo, 32'hFFFFFFFA);
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'h3);
    check("multu.hi_const", hi, 32'h00000002);
    check("multu.lo_const", lo, 32'hFFFFFFFA);

    // Divide
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'h2);
    check("div.lo_const", lo, 32'hFFFFFFFD);
    check("div.hi_const", hi, 32'hFFFFFFFF);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    check("divu.lo_const", lo, 32'd3);
    check("divu.hi_const", hi, 32'd1);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf.lo_const", lo, 32'h80000000);
    check("div_ovf.hi_const", hi, 32'h0);

    // Divide by zero leaves HI/LO alone
    run_op("pre_hi", 3'd4, 32'hAAAA0000, 32'h0);
    run_op("pre_lo", 3'd5, 32'h0000BBBB, 32'h0);
    run_op("div0", 3'd2, 32'd5, 32'd0);
    check("div0.hi_const", hi, 32'hAAAA0000);
    check("div0.lo_const", lo, 32'h0000BBBB);

    // Starts while busy are ignored
    start = 1'b1; md_op = 3'd0; input_1 = 32'd3; input_2 = 32'd4;
    @(negedge clk);
    n = 0;
    if (busy === 1'b1) n++;
    md_op = 3'd5; input_1 = 32'hDEADBEEF; input_2 = 32'h0;
    @(negedge clk);
    if (busy === 1'b1) n++;
    md_op = 3'd2; input_1 = 32'd9; input_2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("collide.busy_cycles", 32'(n), 32'd5);
    model_apply(3'd0, 32'd3, 32'd4);
    check("collide.hi", hi, 32'h0);
    check("collide.lo", lo, 32'd12);
    // Back-to-back: start in the first idle cycle
    run_op("b2b", 3'd1, 32'd6, 32'd7);

    // Reset during an operation
    start = 1'b1; md_op = 3'd3; input_1 = 32'd100; input_2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      if (n == 4) break;
      @(negedge clk);
    end
    check("rst_mid.reached", 32'(n), 32'd4);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    check("rst_mid.busy", 32'(busy), 32'h0);
    check("rst_mid.hi", hi, 32'h0);
    check("rst_mid.lo", lo, 32'h0);
    repeat (12) @(negedge clk);
    check("rst_mid.late_busy", 32'(busy), 32'h0);
    check("rst_mid.late_hi", hi, 32'h0);
    check("rst_mid.late_lo", lo, 32'h0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, beside the ALU.
- Consumes the same operand pair as the ALU (input_1 = rs value, input_2 = rt value) and owns the HI/LO registers.
- Asserts busy so the upstream control stalls later mult/div/mfhi/mflo instructions until the result lands.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO update for mult/multu (must be >=1).
- DIV_CYCLES, 10, cycles from accepted start to HI/LO update for div/divu (must be >=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only on a rising edge while busy=0.
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
- input_1  input  32  operand A (rs): multiplicand/dividend, or the mthi/mtlo source.
- input_2  input  32  operand B (rt): multiplier/divisor.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset:
  - Edge with reset=0 forces busy=0, hi=0, lo=0, counter=0, FSM=IDLE.
  - Reset has priority over everything and aborts an operation in flight; no partial result is written.
- FSM states: IDLE, RUN.
- IDLE, start=1, md_op in {000..011}:
  - At edge T0, latch md_op, input_1 and input_2 into internal registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 after T0.
  - Operand ports are don't-care after T0.
- RUN:
  - Counter decrements each edge.
  - At edge T0+N (N = selected latency), write hi/lo, set busy=0, return to IDLE.
  - busy is high for exactly N cycles.
  - hi/lo hold their old values throughout RUN.
- Back-to-back: start may be re-asserted in the cycle after busy falls; the new op is accepted at that edge.
- IDLE, start=1, md_op=100 (mthi): hi<=input_1 at T0; lo unchanged; busy stays 0.
- IDLE, start=1, md_op=101 (mtlo): lo<=input_1 at T0; hi unchanged; busy stays 0.
- md_op 110/111: no state change, busy stays 0.
- start=1 while busy=1: ignored entirely. No queueing, no restart, no operand capture. Upstream is required to stall; the unit does not flag an error.
- mult: signed 32x32 -> 64-bit product; {hi,lo} = product.
- multu: unsigned 32x32 -> 64-bit product; {hi,lo} = product.
- div: signed division.
  - lo = quotient, truncated toward zero.
  - hi = remainder, sign follows the dividend, |hi| < |divisor|.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- divu: unsigned division; lo = quotient, hi = remainder.
- Divide by zero (div/divu, input_2=0): full DIV_CYCLES busy period still runs; hi and lo remain unchanged at completion.
- Implementation may compute in one cycle and delay the write, or iterate. Visible timing must match the above exactly.
- Outputs are registered; no combinational path from inputs to hi/lo/busy.

Test Plan:
1. Reset sequence:
   - Stimulus: hold reset=0 for 2 edges.
   - Required: hi=0, lo=0, busy=0. Then reset=1, mthi with input_1=0x12345678 gives hi=0x12345678, lo=0 one edge later.
2. Signed multiply:
   - Stimulus: mult with 0xFFFFFFFE (-2) x 0x00000003.
   - Required: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
   - Repeat as multu on the same operands: hi=0x00000002, lo=0xFFFFFFFA.
3. Signed divide:
   - Stimulus: div with -7 (0xFFFFFFF9) / 2.
   - Required: after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - Stimulus: divu with 7/2. Required: lo=3, hi=1.
   - Stimulus: div with 0x80000000 / 0xFFFFFFFF. Required: lo=0x80000000, hi=0.
4. Divide by zero:
   - Stimulus: preload hi=0xAAAA0000, lo=0x0000BBBB via mthi/mtlo; then div with 5/0.
   - Required: busy high 10 cycles; hi/lo unchanged after.
5. Busy collision:
   - Stimulus: during a running mult (3*4), pulse start with mtlo input_1=0xDEADBEEF and again with div 9/3.
   - Required: both ignored; completion gives hi=0, lo=12; busy falls on schedule.
   - Stimulus: start issued the cycle busy falls. Required: accepted.
6. Reset mid-operation:
   - Stimulus: start divu 100/7; assert reset=0 on the 4th busy cycle.
   - Required: next edge busy=0, hi=0, lo=0; no later write occurs.
